// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: samples HS/VS/RGB, recovers pixel coordinates from
// the sync edges, checks line/frame timing and reports a per-frame checksum.
module vga_rx_monitor #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        HS,
  input  logic        VS,
  input  logic [3:0]  R,
  input  logic [3:0]  G,
  input  logic [3:0]  B,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic        locked,
  output logic        err_pulse,
  output logic [7:0]  err_count
);

  localparam logic [10:0] HTOT_L = 11'(H_TOTAL);
  localparam logic [9:0]  HSW_L  = 10'(H_SYNC);
  localparam logic [9:0]  HST_L  = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  HEND_L = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] VTOT_L = 11'(V_TOTAL);
  localparam logic [3:0]  VSW_L  = 4'(V_SYNC);
  localparam logic [9:0]  VST_L  = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  VEND_L = 10'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  logic        hs1, vs1, hs2, vs2;
  logic [11:0] rgb1;
  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic [9:0]  hcnt, hcnt_cur, lcnt, lcnt_cur;
  logic [3:0]  vlow, vlow_cur;
  logic        h_seen, v_seen, viol, active, pv_nxt, enter_search;
  logic        acq_bad, lock_full, fd_nxt;
  logic [15:0] acc;
  state_t      state, state_nxt;

  // Pin sampling (stage 1) and previous copies for edge detection (stage 2).
  // Sync copies idle high so reset release does not fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1 <= 1'b1; vs1 <= 1'b1; hs2 <= 1'b1; vs2 <= 1'b1;
      rgb1 <= '0;
    end else begin
      hs1 <= HS; vs1 <= VS; hs2 <= hs1; vs2 <= vs1;
      rgb1 <= {R, G, B};
    end
  end

  assign hs_fall = hs2 & ~hs1;
  assign hs_rise = ~hs2 & hs1;
  assign vs_fall = vs2 & ~vs1;
  assign vs_rise = ~vs2 & vs1;

  // Counter values that belong to the stage-1 sample of this cycle.
  always_comb begin
    hcnt_cur = (hcnt == 10'h3FF) ? hcnt : hcnt + 10'd1;
    if (hs_fall) hcnt_cur = '0;
    lcnt_cur = lcnt;
    if (vs_fall) lcnt_cur = '0;
    else if (hs_fall && lcnt != 10'h3FF) lcnt_cur = lcnt + 10'd1;
    vlow_cur = vlow;
    if (vs_fall) vlow_cur = {3'b000, hs_fall};
    else if (!vs1 && hs_fall && vlow != 4'hF) vlow_cur = vlow + 4'd1;
  end

  // Any timing violation this cycle; several at once still count as one.
  assign viol = (hs_fall && h_seen && (({1'b0, hcnt} + 11'd1) != HTOT_L)) ||
                (hs_rise && (hcnt_cur != HSW_L)) ||
                (vs_fall && v_seen && (({1'b0, lcnt} + 11'd1) != VTOT_L)) ||
                (vs_rise && (vlow != VSW_L));

  assign active = (hcnt_cur >= HST_L) && (hcnt_cur < HEND_L) &&
                  (lcnt_cur >= VST_L) && (lcnt_cur < VEND_L);
  assign pv_nxt = (state == LOCKED) && active;
  assign enter_search = (state_nxt == SEARCH) && (state != SEARCH);
  assign fd_nxt = vs_fall && (state == LOCKED) && lock_full && !viol;

  // Lock FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (vs_fall) state_nxt = ACQUIRE;
      ACQUIRE: if (vs_fall && !acq_bad && !viol) state_nxt = LOCKED;
      LOCKED:  if (viol) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  // Position counters and the "previous edge seen" flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0; lcnt <= '0; vlow <= '0;
      h_seen <= 1'b0; v_seen <= 1'b0;
    end else begin
      hcnt <= hcnt_cur; lcnt <= lcnt_cur; vlow <= vlow_cur;
      if (enter_search) begin
        h_seen <= 1'b0; v_seen <= 1'b0;
      end else begin
        if (hs_fall) h_seen <= 1'b1;
        if (vs_fall) v_seen <= 1'b1;
      end
    end
  end

  // FSM state, ACQUIRE window health, and whole-frame-locked tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEARCH; acq_bad <= 1'b0; lock_full <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state != ACQUIRE || vs_fall) acq_bad <= 1'b0;
      else if (viol) acq_bad <= 1'b1;
      lock_full <= (state_nxt == LOCKED) && (lock_full || vs_fall);
    end
  end

  // Registered pixel stream, checksum and error reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0; pix_x <= '0; pix_y <= '0; pix_rgb <= '0;
      frame_done <= 1'b0; frame_sum <= '0; locked <= 1'b0;
      err_pulse <= 1'b0; err_count <= '0; acc <= '0;
    end else begin
      pix_valid <= pv_nxt;
      if (pv_nxt) begin
        pix_x   <= hcnt_cur - HST_L;
        pix_y   <= 9'(lcnt_cur - VST_L);
        pix_rgb <= rgb1;
      end
      if (vs_fall) acc <= '0;
      else if (pv_nxt) acc <= acc + {4'h0, rgb1};
      frame_done <= fd_nxt;
      if (fd_nxt) frame_sum <= acc;
      locked    <= (state_nxt == LOCKED);
      err_pulse <= viol;
      if (viol && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule
